shift_right_seq: RTL and testbench
==================================

Name: shift_right_seq

Overview:
- Multi-cycle logical/arithmetic right shifter for the MIPS datapath.
- Executes srl/sra/srlv/srav as the opposite-direction counterpart of the combinational left-shift-by-2 used for branch targets.
- Sits beside the ALU and is driven by the control unit through a start/done handshake.
- Shifts one bit position per clock, so there is no 32-way barrel mux.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand; sampled with start.
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1; sampled with start.
- arith  input  1  1 = arithmetic (sign-fill, sra); 0 = logical (zero-fill, srl).
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion strobe.
- y  output  WIDTH  result; holds until the next accepted start.

Behaviour:
- Reset: async on rst_n low, at any time including mid-operation. state=IDLE, y=0, done=0, busy=0, internal count=0, sign=0. Any operation in flight is abandoned; no done is produced for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1 (call it E0): latch y<=a, count<=shamt, sign<=arith & a[WIDTH-1].
  - If shamt==0, go to DONE; otherwise go to SHIFT.
  - start=0: stay in IDLE; y holds.
- SHIFT, each edge:
  - y <= {sign, y[WIDTH-1:1]}; count <= count-1.
  - When count==1 at the edge, go to DONE.
- DONE:
  - done=1 for exactly this one cycle; y is valid and final.
  - Next edge goes to IDLE unconditionally.
- Timing: done is high in the cycle after edge E_shamt (the shamt-th edge after E0). shamt=0 gives done in the cycle right after E0. Maximum is 31 shift cycles plus the DONE cycle.
- start while busy (SHIFT or DONE): ignored. Operands are not re-sampled and there is no queueing. Back-to-back throughput is one operation per shamt+2 cycles.
- a, shamt, arith may change freely after E0; only the latched copies are used.
- y after done: holds its value through IDLE until the next accepted start overwrites it at that start's E0.
- Sign fill: sign is captured once at E0. Logical mode always fills with 0.

Optional Feature:
- Macro: SHR_NIBBLE_STEP_EN.
- Defined:
  - In SHIFT, when count>=4, shift by 4 (four copies of sign) and decrement count by 4; otherwise shift by 1.
  - The transition to DONE happens when count reaches 0 after the step.
  - Cycles in SHIFT = floor(shamt/4) + (shamt mod 4).
- Undefined: strictly 1 bit per cycle as described above.
- Results are bit-identical in both builds.

Decomposition:
- Package mips_shift_pkg holds:
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - WIDTH_DEF=32 and SHAMT_W_DEF=5;
  - step constant NIBBLE=4.
- One natural combinational sub-module, shift_right_step. Inputs are data, sign and step (1 or 4); output is the shifted data. It is instantiated once in the datapath; the FSM and counter stay in shift_right_seq.

Test Plan:
- SRL: a=0x80000000, shamt=4, arith=0 -> y=0x08000000; done high only in the cycle after E4; busy high E0..E5.
- SRA: a=0x80000000, shamt=4, arith=1 -> y=0xF8000000. Then a=0x70000000, shamt=4, arith=1 -> y=0x07000000 (positive operand, zero fill).
- shamt=0: a=0x12345678 -> done in the cycle after E0, y=0x12345678, back in IDLE after E1.
- shamt=31, a=0x80000000: arith=1 -> y=0xFFFFFFFF; arith=0 -> y=0x00000001; done after E31 in both cases.
- Robustness: start with a=0xDEADBEEF pulsed during SHIFT of a shamt=8 op -> ignored, first op still completes correctly. Then rst_n=0 asserted between E2 and E3 of a new op -> immediately y=0, busy=0, done=0, and no later done for that op.
- With SHR_NIBBLE_STEP_EN: a=0xF0000000, shamt=9, arith=1 -> y=0xFFF80000 with done after E3 (2 nibble steps + 1 bit step); same result as the default build, which completes after E9.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// ---------------------------------------------------------------------------
// mips_shift_pkg
//
// Purpose:
//   Shared definitions for the multi-cycle right shifter that sits beside the
//   MIPS ALU. Holds the FSM state encoding, the default data and shift-amount
//   widths, and the nibble step size used when coarse stepping is built in.
//
// Contents:
//   state_t      - controller states IDLE / SHIFT / DONE
//   WIDTH_DEF    - default datapath width (32)
//   SHAMT_W_DEF  - default shift-amount width (5 = clog2(32))
//   NIBBLE       - bit count of one coarse shift step (4)
// ---------------------------------------------------------------------------
package mips_shift_pkg;

  // Controller states. The numeric values are fixed so that waveforms and any
  // debug taps read the same in every build.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default geometry for a 32-bit MIPS datapath.
  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // Size of one coarse step. Step-select encodings use this value directly,
  // so a step input equal to NIBBLE means "shift by four".
  localparam int NIBBLE = 4;

endpackage : mips_shift_pkg

// File: rtl/shift_right_step.sv
// ---------------------------------------------------------------------------
// shift_right_step
//
// Purpose:
//   One combinational step of a right shift. Moves the data right by either
//   one bit or NIBBLE bits, filling the vacated top bits with the supplied
//   sign bit (0 for logical shifts, the operand's MSB for arithmetic shifts).
//
// Parameters:
//   WIDTH    - data width in bits (must be larger than NIBBLE)
//
// Ports:
//   data_i   in  [WIDTH-1:0]  value to shift
//   sign_i   in  1            fill bit for the vacated positions
//   step_i   in  [2:0]        shift distance; NIBBLE selects a nibble step,
//                             every other value selects a single-bit step
//   data_o   out [WIDTH-1:0]  shifted value
// ---------------------------------------------------------------------------
module shift_right_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             sign_i,
  input  logic [2:0]       step_i,
  output logic [WIDTH-1:0] data_o
);

  // Only two distances are ever requested, so this is a two-way mux rather
  // than a barrel shifter. Anything that is not a nibble request falls back
  // to a single-bit shift, which keeps the default build's behaviour safe
  // even if the controller ever presented an unexpected step code.
  always_comb begin
    data_o = {sign_i, data_i[WIDTH-1:1]};
    if (step_i == 3'(NIBBLE)) begin
      data_o = {{NIBBLE{sign_i}}, data_i[WIDTH-1:NIBBLE]};
    end
  end

endmodule : shift_right_step

// File: rtl/shift_right_seq.sv
// ---------------------------------------------------------------------------
// shift_right_seq
//
// Purpose:
//   Multi-cycle logical/arithmetic right shifter for the MIPS datapath
//   (srl / sra / srlv / srav). The control unit starts an operation with a
//   one-cycle start pulse while the block is idle; the result appears on y
//   and a one-cycle done strobe marks its completion. The data is shifted one
//   bit per clock so no 32-way barrel mux is needed.
//
// Build option:
//   SHR_NIBBLE_STEP_EN - when defined, the shifter moves four bits per clock
//                        while at least four positions remain, then finishes
//                        one bit per clock. Results are bit-identical to the
//                        default build; only the latency shrinks.
//
// Parameters:
//   WIDTH    - data width in bits (default 32)
//   SHAMT_W  - shift-amount width, must equal clog2(WIDTH) (default 5)
//
// Ports:
//   clk      in  1          system clock, rising-edge active
//   rst_n    in  1          asynchronous active-low reset
//   start    in  1          request pulse, sampled only in IDLE
//   a        in  WIDTH      operand, sampled with start
//   shamt    in  SHAMT_W    shift amount 0..WIDTH-1, sampled with start
//   arith    in  1          1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy     out 1          high whenever the controller is not in IDLE
//   done     out 1          one-cycle completion strobe
//   y        out WIDTH      result; holds until the next accepted start
// ---------------------------------------------------------------------------
module shift_right_seq
  import mips_shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic                 sign_q, sign_d;

  logic [2:0]           stepSize;
  logic [SHAMT_W-1:0]   countAfterStep;
  logic [WIDTH-1:0]     yShifted;

  // Choose how far the datapath moves this cycle. In the coarse build a
  // nibble step is taken whenever at least four positions remain, so the
  // remaining count can never underflow; the tail is finished bit by bit.
  always_comb begin
`ifdef SHR_NIBBLE_STEP_EN
    if (count_q >= SHAMT_W'(NIBBLE)) begin
      stepSize = 3'(NIBBLE);
    end else begin
      stepSize = 3'd1;
    end
`else
    stepSize = 3'd1;
`endif
    countAfterStep = count_q - SHAMT_W'(stepSize);
  end

  // The single shared shift stage. The sign bit was frozen when the
  // operation was accepted, so later edits to a or arith cannot leak in.
  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (y_q),
    .sign_i (sign_q),
    .step_i (stepSize),
    .data_o (yShifted)
  );

  // Next-state and datapath update. Operands are latched only in IDLE, which
  // is what makes a start pulse during SHIFT or DONE harmless: nothing is
  // re-sampled and nothing is queued. A zero shift amount skips SHIFT
  // entirely so done follows the accepting edge directly.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    count_d = count_q;
    sign_d  = sign_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          y_d     = a;
          count_d = shamt;
          sign_d  = arith & a[WIDTH-1];
          if (shamt == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        y_d     = yShifted;
        count_d = countAfterStep;
        if (countAfterStep == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset may arrive at any point, including mid-shift;
  // it abandons the operation outright and clears the result, so no done
  // strobe is ever produced for the interrupted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      count_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      count_q <= count_d;
      sign_q  <= sign_d;
    end
  end

  // Status outputs decode straight from the state register, so done is
  // high for exactly the one cycle spent in DONE.
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign y    = y_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_right_seq
//
// Directed testbench for shift_right_seq. Each operation is launched with a
// start pulse, after which the bench follows the handshake cycle by cycle and
// compares result, done position, done count and busy duration against
// hand-computed values. Expected latency follows SHR_NIBBLE_STEP_EN.
// ---------------------------------------------------------------------------
module tb_shift_right_seq;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [SW-1:0] shamt;
  logic          arith;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;

  int checks   = 0;
  int failures = 0;

  shift_right_seq #(
    .WIDTH   (W),
    .SHAMT_W (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of cycles the controller should spend in SHIFT for a shift amount.
  function automatic int shiftCycles(input int sh);
`ifdef SHR_NIBBLE_STEP_EN
    return (sh / 4) + (sh % 4);
`else
    return sh;
`endif
  endfunction

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Launch one operation and follow it to IDLE. Edge E0 accepts the request;
  // the negedge sampled after edge E0+j is called cycle j. Done is expected
  // at cycle shiftCycles(sh) and IDLE one cycle later. If injectAt >= 0, a
  // bogus start with different operands is driven during that busy cycle.
  task automatic applyStimulus(input string tag, input logic [W-1:0] opA,
                               input int sh, input logic opArith,
                               input logic [W-1:0] expY, input int injectAt);
    int doneAt    = -1;
    int doneCount = 0;
    int idleAt    = -1;
    logic [W-1:0] yAtDone = '0;
    int expDone   = shiftCycles(sh);

    @(negedge clk);
    start = 1'b1;
    a     = opA;
    shamt = SW'(sh);
    arith = opArith;
    @(posedge clk);
    #1;
    // Scramble the operand inputs so only the latched copies can matter.
    start = 1'b0;
    a     = ~opA;
    shamt = ~SW'(sh);
    arith = ~opArith;

    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      if (j == injectAt) begin
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        shamt = 5'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneCount++;
        if (doneAt < 0) begin
          doneAt  = j;
          yAtDone = y;
        end
      end
      if (!busy) begin
        idleAt = j;
        break;
      end
    end
    start = 1'b0;

    checkOutput({tag, " y"},        yAtDone,          expY);
    checkOutput({tag, " doneAt"},   32'(doneAt),      32'(expDone));
    checkOutput({tag, " doneCnt"},  32'(doneCount),   32'd1);
    checkOutput({tag, " idleAt"},   32'(idleAt),      32'(expDone + 1));
    @(negedge clk);
    checkOutput({tag, " yHold"},    y,                expY);
  endtask

  initial begin
    int lateDone;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    shamt = '0;
    arith = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset y",    y,            32'h0);
    checkOutput("reset busy", 32'(busy),    32'd0);
    checkOutput("reset done", 32'(done),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("srl4",    32'h8000_0000, 4,  1'b0, 32'h0800_0000, -1);
    applyStimulus("sra4neg", 32'h8000_0000, 4,  1'b1, 32'hF800_0000, -1);
    applyStimulus("sra4pos", 32'h7000_0000, 4,  1'b1, 32'h0700_0000, -1);
    applyStimulus("sh0",     32'h1234_5678, 0,  1'b1, 32'h1234_5678, -1);
    applyStimulus("sra31",   32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, -1);
    applyStimulus("srl31",   32'h8000_0000, 31, 1'b0, 32'h0000_0001, -1);
    applyStimulus("sra9",    32'hF000_0000, 9,  1'b1, 32'hFFF8_0000, -1);
    applyStimulus("sra7",    32'h9ABC_DEF0, 7,  1'b1, 32'hFF35_79BD, -1);
    applyStimulus("busyIgn", 32'hF0F0_F0F0, 8,  1'b1, 32'hFFF0_F0F0, 1);

    // Reset between E2 and E3 of a fresh operation must abandon it at once.
    @(negedge clk);
    start = 1'b1;
    a     = 32'h1234_5678;
    shamt = 5'd8;
    arith = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst y",    y,         32'h0);
    checkOutput("midRst busy", 32'(busy), 32'd0);
    checkOutput("midRst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lateDone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) lateDone++;
    end
    checkOutput("midRst noLateDone", 32'(lateDone), 32'd0);
    checkOutput("midRst yStays0",    y,             32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_right_seq
